// File: rtl/fetch_seq.sv
// Generic SM83 instruction-fetch sequencer: opcode beat, 0..MAX_IMM immediate beats,
// then a valid/ready hand-off of the assembled instruction to execute.
module fetch_seq #(
    parameter int unsigned            ADDR_W    = 16,
    parameter logic [ADDR_W-1:0]      RESET_VEC = 16'h0000,
    parameter int unsigned            MAX_IMM   = 2,
    parameter int unsigned            LEN_W     = $clog2(MAX_IMM + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_rd,
    input  logic                      mem_rdy,
    input  logic [7:0]                mem_data,
    output logic [7:0]                opcode,
    input  logic [LEN_W-1:0]          op_len,
    output logic                      instr_vld,
    input  logic                      instr_rdy,
    output logic [8*MAX_IMM-1:0]      imm,
    output logic                      illegal,
    input  logic                      jump_en,
    input  logic [ADDR_W-1:0]         jump_addr,
    output logic [ADDR_W-1:0]         pc
);

    localparam int unsigned IMM_W = 8 * MAX_IMM;

    typedef enum logic [2:0] {
        S_RST   = 3'd0,
        S_OP    = 3'd1,
        S_DEC   = 3'd2,
        S_IMM   = 3'd3,
        S_ISSUE = 3'd4
    } state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic [7:0]         r_opcode;
    logic [IMM_W-1:0]   r_imm;
    logic [LEN_W-1:0]   r_cnt;
    logic [LEN_W-1:0]   r_len;
    logic               r_illegal;

    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  w_pc_nxt;
    logic [7:0]         w_opcode_nxt;
    logic [IMM_W-1:0]   w_imm_nxt;
    logic [LEN_W-1:0]   w_cnt_nxt;
    logic [LEN_W-1:0]   w_len_nxt;
    logic               w_illegal_nxt;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_RST;
            r_pc      <= RESET_VEC;
            r_opcode  <= 8'h00;
            r_imm     <= '0;
            r_cnt     <= '0;
            r_len     <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_opcode  <= w_opcode_nxt;
            r_imm     <= w_imm_nxt;
            r_cnt     <= w_cnt_nxt;
            r_len     <= w_len_nxt;
            r_illegal <= w_illegal_nxt;
        end
    end

    // Next-state and datapath update
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_opcode_nxt  = r_opcode;
        w_imm_nxt     = r_imm;
        w_cnt_nxt     = r_cnt;
        w_len_nxt     = r_len;
        w_illegal_nxt = r_illegal;

        case (r_state)
            S_RST: begin
                w_state_nxt = S_OP;
            end
            S_OP: begin
                if (mem_rdy) begin
                    w_opcode_nxt = mem_data;
                    w_pc_nxt     = r_pc + ADDR_W'(1);
                    w_imm_nxt    = '0;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = S_DEC;
                end
            end
            S_DEC: begin
                if (op_len == '0) begin
                    w_state_nxt = S_ISSUE;
                end else if (op_len > LEN_W'(MAX_IMM)) begin
                    // Over-long length: issue flagged, no immediate bytes consumed
                    w_illegal_nxt = 1'b1;
                    w_state_nxt   = S_ISSUE;
                end else begin
                    w_len_nxt   = op_len;
                    w_state_nxt = S_IMM;
                end
            end
            S_IMM: begin
                if (mem_rdy) begin
                    for (int unsigned k = 0; k < MAX_IMM; k++) begin
                        if (r_cnt == LEN_W'(k)) begin
                            w_imm_nxt[8*k +: 8] = mem_data;
                        end
                    end
                    w_pc_nxt  = r_pc + ADDR_W'(1);
                    w_cnt_nxt = r_cnt + LEN_W'(1);
                    if (r_cnt == r_len - LEN_W'(1)) begin
                        w_state_nxt = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (instr_rdy) begin
                    w_illegal_nxt = 1'b0;
                    w_state_nxt   = S_OP;
                    if (jump_en) begin
                        w_pc_nxt = jump_addr;
                    end
                end
            end
            default: begin
                w_state_nxt = S_RST;
            end
        endcase
    end

    // Moore outputs decoded from the state register
    assign mem_rd    = (r_state == S_OP) || (r_state == S_IMM);
    assign instr_vld = (r_state == S_ISSUE);
    assign mem_addr  = r_pc;
    assign pc        = r_pc;
    assign opcode    = r_opcode;
    assign imm       = r_imm;
    assign illegal   = r_illegal;

endmodule
